// File: rtl/cycle_digit_counter.sv
// One down-counting digit of a cascaded cycle timer: loads a clamped preset, decrements on
// rising edges of dec_in, borrows from / signals completion to the higher digit, and latches stage LEDs.
module cycle_digit_counter #(
  parameter int WIDTH   = 4,
  parameter int MAXVAL  = 9,
  parameter int STAGE_A = 3,
  parameter int STAGE_B = 2
) (
  input  logic             CLK100MHZ,
  input  logic             CPU_RESETN,
  input  logic             dec_in,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             enable,
  input  logic             abort,
  input  logic             hi_nonzero,
  output logic [WIDTH-1:0] count,
  output logic             borrowout,
  output logic             busy,
  output logic             done,
  output logic [1:0]       stage_led
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_PAUSE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [WIDTH-1:0] MAX_V     = WIDTH'(MAXVAL);
  localparam logic [WIDTH-1:0] STAGE_A_V = WIDTH'(STAGE_A);
  localparam logic [WIDTH-1:0] STAGE_B_V = WIDTH'(STAGE_B);

  logic [1:0]       state_reg, state_next;
  logic [WIDTH-1:0] count_reg, count_next;
  logic [1:0]       led_reg, led_next;
  logic             borrow_reg, borrow_next;
  logic             done_reg, done_next;
  logic             prev_dec_reg;
  logic             dec_edge;
  logic [WIDTH-1:0] clamped_val;

  assign dec_edge    = dec_in & ~prev_dec_reg;
  assign clamped_val = (load_val > MAX_V) ? MAX_V : load_val;

  always_comb begin
    state_next  = state_reg;
    count_next  = count_reg;
    led_next    = led_reg;
    borrow_next = 1'b0;
    done_next   = 1'b0;

    if (abort) begin
      state_next = S_IDLE;
      count_next = '0;
      led_next   = 2'b00;
    end else if (load) begin
      count_next = clamped_val;
      led_next   = 2'b00;
      state_next = (clamped_val != '0) ? S_RUN : S_IDLE;
    end else begin
      case (state_reg)
        S_RUN: begin
          // Pausing takes precedence over an edge arriving in the same cycle.
          if (!enable) begin
            state_next = S_PAUSE;
          end else if (dec_edge) begin
            if (count_reg != '0) begin
              count_next = count_reg - WIDTH'(1);
              if (count_reg == STAGE_A_V) led_next[0] = 1'b1;
              if (count_reg == STAGE_B_V) led_next[1] = 1'b1;
            end else if (hi_nonzero) begin
              count_next  = MAX_V;
              borrow_next = 1'b1;
            end else begin
              state_next = S_DONE;
              done_next  = 1'b1;
            end
          end
        end
        S_PAUSE: begin
          if (enable) state_next = S_RUN;
        end
        default: ;
      endcase
    end
  end

  // prev_dec resets high so a dec_in held high through reset release is not seen as an edge.
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      state_reg    <= S_IDLE;
      count_reg    <= '0;
      led_reg      <= 2'b00;
      borrow_reg   <= 1'b0;
      done_reg     <= 1'b0;
      prev_dec_reg <= 1'b1;
    end else begin
      state_reg    <= state_next;
      count_reg    <= count_next;
      led_reg      <= led_next;
      borrow_reg   <= borrow_next;
      done_reg     <= done_next;
      prev_dec_reg <= dec_in;
    end
  end

  assign count     = count_reg;
  assign borrowout = borrow_reg;
  assign done      = done_reg;
  assign stage_led = led_reg;
  assign busy      = (state_reg == S_RUN) | (state_reg == S_PAUSE);

endmodule

// File: tb/tb_cycle_digit_counter.sv
// Bench for cycle_digit_counter: directed scenarios followed by random stimulus, all checked
// every cycle against a behavioural digit model.
module tb_cycle_digit_counter;

  localparam int WIDTH  = 4;
  localparam int MAXVAL = 9;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             dec_in, load, enable, abort, hi_nonzero;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] count;
  logic             borrowout, busy, done;
  logic [1:0]       stage_led;

  int n_cmp = 0;
  int n_err = 0;

  typedef enum {M_IDLE, M_RUN, M_PAUSE, M_DONE} mode_t;
  mode_t m_mode;
  int    m_count;
  bit    m_prev, m_borrow, m_done;
  bit    m_led0, m_led1;

  always #5 clk = ~clk;

  cycle_digit_counter #(.WIDTH(WIDTH), .MAXVAL(MAXVAL), .STAGE_A(3), .STAGE_B(2)) dut (
    .CLK100MHZ (clk),
    .CPU_RESETN(rst_n),
    .dec_in    (dec_in),
    .load      (load),
    .load_val  (load_val),
    .enable    (enable),
    .abort     (abort),
    .hi_nonzero(hi_nonzero),
    .count     (count),
    .borrowout (borrowout),
    .busy      (busy),
    .done      (done),
    .stage_led (stage_led)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    m_mode = M_IDLE; m_count = 0; m_prev = 1'b1;
    m_borrow = 1'b0; m_done = 1'b0; m_led0 = 1'b0; m_led1 = 1'b0;
  endfunction

  // Behaviour of one digit for one clock, derived from the timer rules.
  function automatic void model_step();
    bit rising;
    int c;
    rising   = dec_in && !m_prev;
    m_prev   = dec_in;
    m_borrow = 1'b0;
    m_done   = 1'b0;
    if (abort) begin
      m_count = 0; m_mode = M_IDLE; m_led0 = 0; m_led1 = 0;
    end else if (load) begin
      c = (int'(load_val) > MAXVAL) ? MAXVAL : int'(load_val);
      m_count = c; m_led0 = 0; m_led1 = 0;
      m_mode = (c != 0) ? M_RUN : M_IDLE;
    end else if (m_mode == M_RUN) begin
      if (!enable) m_mode = M_PAUSE;
      else if (rising) begin
        if (m_count > 0) begin
          if (m_count == 3) m_led0 = 1;
          if (m_count == 2) m_led1 = 1;
          m_count = m_count - 1;
        end else if (hi_nonzero) begin
          m_count = MAXVAL; m_borrow = 1;
        end else begin
          m_mode = M_DONE; m_done = 1;
        end
      end
    end else if (m_mode == M_PAUSE && enable) begin
      m_mode = M_RUN;
    end
  endfunction

  task automatic compare_all(input string tag);
    check({tag, ".count"},     32'(count),     32'(m_count));
    check({tag, ".borrowout"}, 32'(borrowout), 32'(m_borrow));
    check({tag, ".done"},      32'(done),      32'(m_done));
    check({tag, ".busy"},      32'(busy),      32'(m_mode == M_RUN || m_mode == M_PAUSE));
    check({tag, ".stage_led"}, 32'(stage_led), 32'({m_led1, m_led0}));
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_step();
    #1;
    compare_all(tag);
  endtask

  task automatic edge_pulse(input string tag);
    dec_in = 1'b0; tick(tag);
    dec_in = 1'b1; tick(tag);
  endtask

  task automatic do_load(input int v, input string tag);
    load = 1'b1; load_val = WIDTH'(v); tick(tag);
    load = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; dec_in = 1'b1; load = 1'b0; load_val = '0;
    enable = 1'b1; abort = 1'b0; hi_nonzero = 1'b0;
    model_reset();
    #2;
    compare_all("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick("release_high");
    $display("step reset: count=%0d busy=%0d", count, busy);

    // Basic countdown to completion as the top digit.
    do_load(4, "load4");
    check("load4_count", 32'(count), 32'd4);
    for (int k = 1; k <= 5; k++) begin
      edge_pulse("cd");
      if (k <= 4) check("cd_value", 32'(count), 32'(4 - k));
      $display("step countdown edge %0d: count=%0d leds=%b done=%0d busy=%0d",
               k, count, stage_led, done, busy);
    end
    check("cd_done", 32'(done), 32'd1);
    check("cd_busy", 32'(busy), 32'd0);
    check("cd_leds", 32'(stage_led), 32'd3);
    tick("cd_after");

    // Borrow from the higher digit when reaching zero while it is still nonzero.
    hi_nonzero = 1'b1;
    do_load(1, "load1");
    edge_pulse("to_zero");
    check("zero_busy", 32'(busy), 32'd1);
    edge_pulse("borrow");
    check("borrow_count", 32'(count), 32'd9);
    check("borrow_pulse", 32'(borrowout), 32'd1);
    tick("borrow_clear");
    check("borrow_once", 32'(borrowout), 32'd0);
    edge_pulse("after_borrow");
    check("after_borrow", 32'(count), 32'd8);
    $display("step borrow: count=%0d borrowout=%0d", count, borrowout);

    // Load above MAXVAL clamps.
    do_load(15, "clamp");
    check("clamp_count", 32'(count), 32'd9);
    check("clamp_busy", 32'(busy), 32'd1);
    $display("step clamp: count=%0d busy=%0d", count, busy);

    // Pause ignores edges; resuming with dec_in high must not decrement.
    do_load(5, "load5");
    enable = 1'b0; tick("pause");
    for (int k = 0; k < 3; k++) edge_pulse("paused_edge");
    enable = 1'b1; tick("resume");
    tick("resume2");
    check("pause_hold", 32'(count), 32'd5);
    edge_pulse("resumed_edge");
    check("resumed_dec", 32'(count), 32'd4);
    $display("step pause: count=%0d busy=%0d", count, busy);

    // Priority: abort beats load and edge; load beats edge.
    dec_in = 1'b0; tick("prio_low");
    abort = 1'b1; load = 1'b1; load_val = 4'd7; dec_in = 1'b1; tick("abort_all");
    abort = 1'b0; load = 1'b0;
    check("abort_count", 32'(count), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    do_load(8, "load8");
    dec_in = 1'b0; tick("prio_low2");
    load = 1'b1; load_val = 4'd6; dec_in = 1'b1; tick("load_edge");
    load = 1'b0;
    check("load_edge", 32'(count), 32'd6);
    $display("step priority: count=%0d", count);

    // Asynchronous reset mid-run with dec_in held high.
    do_load(3, "load3");
    #2; rst_n = 1'b0; model_reset(); #1;
    compare_all("async_rst");
    check("async_rst_count", 32'(count), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick("post_rst");
    check("post_rst_count", 32'(count), 32'd0);
    $display("step async reset: count=%0d busy=%0d", count, busy);

    // Random stimulus against the model.
    for (int i = 0; i < 3000; i++) begin
      abort      = ($urandom_range(0, 31) == 0);
      load       = ($urandom_range(0, 15) == 0);
      load_val   = WIDTH'($urandom_range(0, 15));
      enable     = ($urandom_range(0, 7) != 0);
      dec_in     = 1'($urandom_range(0, 1));
      hi_nonzero = ($urandom_range(0, 3) != 0);
      if (i == 1500) begin
        #2; rst_n = 1'b0; model_reset(); #1;
        compare_all("rand_rst");
        @(posedge clk); #1;
        rst_n = 1'b1;
      end
      tick("rand");
    end
    $display("step random: 3000 cycles, count=%0d", count);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
